// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: default width and FSM state encoding.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on magnitudes (purely combinational).
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Borrow out of the trial subtract means the divisor did not fit: restore.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit for the E stage: stalls the pipe while iterating,
// pulses result_valid for one cycle with quotient on lo_out and remainder on hi_out.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_startE,
  input  logic             signed_divE,
  input  logic [WIDTH-1:0] aE,
  input  logic [WIDTH-1:0] bE,
  input  logic             cancel,
  output logic             stall_divE,
  output logic             div_busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] dvs, dvs_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic [WIDTH-1:0] lo_n, hi_n;
  logic             valid_n;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  assign a_abs = (signed_divE && aE[WIDTH-1]) ? -aE : aE;
  assign b_abs = (signed_divE && bE[WIDTH-1]) ? -bE : bE;

  // Hazard-unit handshake; forced low in reset and when the pipe is flushed.
  assign stall_divE = resetn & ~cancel &
                      (((state == S_IDLE) & div_startE) | (state == S_BUSY));
  assign div_busy   = resetn & (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      result_valid <= 1'b0;
      lo_out       <= '0;
      hi_out       <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      rem          <= rem_n;
      quo          <= quo_n;
      dvs          <= dvs_n;
      neg_q        <= neg_q_n;
      neg_r        <= neg_r_n;
      result_valid <= valid_n;
      lo_out       <= lo_n;
      hi_out       <= hi_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    quo_n   = quo;
    dvs_n   = dvs;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    lo_n    = lo_out;
    hi_n    = hi_out;
    valid_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (div_startE) begin
          if (bE == '0) begin
            state_n = S_DONE;
            valid_n = 1'b1;
            lo_n    = '1;
            hi_n    = aE;
          end else begin
            state_n = S_BUSY;
            cnt_n   = '0;
            rem_n   = '0;
            quo_n   = a_abs;
            dvs_n   = b_abs;
            neg_q_n = signed_divE & (aE[WIDTH-1] ^ bE[WIDTH-1]);
            neg_r_n = signed_divE & aE[WIDTH-1];
          end
        end
      end
      S_BUSY: begin
        rem_n = step_rem;
        quo_n = step_quo;
        cnt_n = cnt + CNT_W'(1);
        // Last iteration: sign-correct and publish straight from the step outputs.
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_n = S_DONE;
          valid_n = 1'b1;
          lo_n    = neg_q ? -step_quo : step_quo;
          hi_n    = neg_r ? -step_rem : step_rem;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (cancel) begin
      state_n = S_IDLE;
      valid_n = 1'b0;
      lo_n    = lo_out;
      hi_n    = hi_out;
    end
  end

endmodule
